uart_rx_buf_sched: RTL and testbench
====================================

// Module: uart_rx_buf_sched
// PURPOSE
//  UART 8N1 receiver plus access scheduler for the 128-entry RX byte buffer.
//  Deserialises rx_i and shares the buffer's single addr/wdata/rnw port between
//  received-byte writes and CPU pop requests.
//  Sits between the pad and the RX buffer; CPU pops go through this block, not directly.
// PARAMETERS
//  CLKS_PER_BIT  104           clk cycles per UART bit (12 MHz / 115200); must be >= 4
//  BUF_BASE      32'h0001_0000 buffer address driven on buf_addr_o for any access
// PORTS
//  clk                input   1   system clock, all logic on rising edge
//  rst_n_i            input   1   reset, asynchronous assert, active-low
//  rx_i               input   1   raw UART serial line, idle high, asynchronous
//  cpu_req_i          input   1   CPU requests one byte pop this cycle (level)
//  cpu_ack_o          output  1   pop issued to buffer this cycle
//  buf_addr_o         output  32  buffer address; BUF_BASE when accessing, else 32'h0
//  buf_wdata_o        output  32  {24'b0, rx byte} during write, else 32'h0
//  buf_rnw_o          output  1   1 = read/idle, 0 = write
//  rx_buffer_full_i   input   1   buffer full flag
//  rx_buffer_empty_i  input   1   buffer empty flag
//  frame_err_o        output  1   1-cycle pulse: stop bit sampled low
//  byte_dropped_o     output  1   1-cycle pulse: write attempted while full
//  drop_count_o       output  8   saturating count of dropped bytes
//  rx_busy_o          output  1   FSM not in IDLE
// BEHAVIOUR
//  Reset: FSM=IDLE; sync flops=1; counters=0; every output 0, except buf_rnw_o=1.
//  rx_i passes through a 2-flop synchroniser (rx_s); 2-cycle input latency.
//  FSM: IDLE, START, DATA, [PARITY], STOP, WRITE, WAIT_HI.
//  IDLE:    rx_s==0 -> START; baud_cnt=0.
//  START:   at baud_cnt==CLKS_PER_BIT/2-1, sample rx_s.
//           1 -> IDLE (glitch, nothing written); 0 -> DATA, baud_cnt=0.
//  DATA:    sample every CLKS_PER_BIT cycles (mid-bit), 8 bits LSB first
//           into shift reg; 3-bit bit_idx counts 0..7. After bit 7 -> STOP (or PARITY).
//  STOP:    sample after CLKS_PER_BIT cycles.
//           1 -> WRITE; 0 -> frame_err_o pulse, byte discarded, -> WAIT_HI.
//  WAIT_HI: stay until rx_s==1, then IDLE. A held-low break yields one error only.
//  WRITE:   exactly one cycle, then IDLE.
//           Bus outputs (combinational from state): addr=BASE, rnw=0, wdata={24'b0,byte}.
//           If rx_buffer_full_i: byte_dropped_o pulses next cycle; drop_count_o +1,
//           saturating at 8'hFF.
//  Arbitration:
//   - WRITE always wins.
//   - cpu_ack_o = cpu_req_i && state!=WRITE && !rx_buffer_empty_i.
//   - On ack: addr=BASE, rnw=1. Data is returned by the buffer on rdata next cycle.
//   - Req while empty: no ack, bus idle (addr=0, rnw=1).
//   - Req in WRITE cycle: CPU retries; the next cycle is never WRITE, so max wait = 1 cycle.
//  Simultaneous write to full buffer and CPU pop: write is issued first and dropped.
//  Reset mid-frame: partial byte discarded, no write; bus returns to idle immediately.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//   - PARITY state between DATA and STOP samples an even-parity bit.
//   - Mismatch -> frame_err_o pulse, byte discarded, -> WAIT_HI.
//  Not defined: 8N1; PARITY state and logic absent.
// TESTING
//  Send 0x55 8N1 at CLKS_PER_BIT=8 -> one WRITE cycle, wdata=32'h55, rnw=0;
//   rx_busy_o low afterwards.
//  Low glitch of 3 cycles on rx_i -> back to IDLE; no write, no frame_err_o.
//  Send 0xA3 with stop bit 0 -> frame_err_o pulses once; no write;
//   IDLE only after rx_i goes high.
//  Force rx_buffer_full_i=1, send 0x10 -> byte_dropped_o pulse, drop_count_o=1;
//   300 drops -> drop_count_o=8'hFF.
//  cpu_req_i held high across a WRITE cycle, buffer non-empty ->
//   cpu_ack_o=0 in WRITE cycle, 1 the next cycle with rnw=1.
//  With UART_RX_PARITY_EN: 0x07 with parity bit 0 -> frame_err_o;
//   with parity bit 1 -> write 32'h07.

Source files
------------

// File: rtl/uart_rx_buf_sched.sv
// uart_rx_buf_sched: UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is
// defined) feeding a 128-entry RX buffer, with a scheduler that shares the
// buffer's single addr/wdata/rnw port between received-byte writes and CPU pops.
// Optional feature macro: UART_RX_PARITY_EN (even parity bit between data and stop).
module uart_rx_buf_sched #(
  parameter int          CLKS_PER_BIT = 104,
  parameter logic [31:0] BUF_BASE     = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst_n_i,
  input  logic        rx_i,
  input  logic        cpu_req_i,
  output logic        cpu_ack_o,
  output logic [31:0] buf_addr_o,
  output logic [31:0] buf_wdata_o,
  output logic        buf_rnw_o,
  input  logic        rx_buffer_full_i,
  input  logic        rx_buffer_empty_i,
  output logic        frame_err_o,
  output logic        byte_dropped_o,
  output logic [7:0]  drop_count_o,
  output logic        rx_busy_o
);

  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WRITE,
    S_WAIT_HI
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            rx_meta;
  logic            rx_s;
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            sample;
  logic            counting;
  logic            stop_bad;
  logic            parity_bad;
  logic            frame_err;
  logic            byte_dropped;
  logic [7:0]      drop_cnt;

  // Two-flop synchroniser for the asynchronous serial line; idles high.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  // Sample strobe: half a bit into START, then once per bit period.
  always_comb begin
    sample   = 1'b0;
    counting = 1'b0;
    case (state)
      S_START: begin
        counting = 1'b1;
        sample   = (baud_cnt == HALF_LAST);
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_DATA, S_STOP: begin
        counting = 1'b1;
        sample   = (baud_cnt == BIT_LAST);
      end
      default: ;
    endcase
  end

  // Frame error conditions evaluated at the sample point.
  always_comb begin
    stop_bad   = (state == S_STOP) && sample && !rx_s;
    parity_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad = (state == S_PARITY) && sample && (rx_s != ^shift);
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) state <= S_IDLE;
    else          state <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (!rx_s) state_next = S_START;
      S_START:   if (sample) state_next = rx_s ? S_IDLE : S_DATA;
      S_DATA: begin
        if (sample && (bit_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          state_next = S_PARITY;
`else
          state_next = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY:  if (sample) state_next = parity_bad ? S_WAIT_HI : S_STOP;
`endif
      S_STOP:    if (sample) state_next = rx_s ? S_WRITE : S_WAIT_HI;
      S_WRITE:   state_next = S_IDLE;
      S_WAIT_HI: if (rx_s) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // FSM outputs: the write cycle owns the bus; otherwise a CPU pop may use it.
  always_comb begin
    rx_busy_o   = (state != S_IDLE);
    cpu_ack_o   = rst_n_i && cpu_req_i && (state != S_WRITE) && !rx_buffer_empty_i;
    buf_addr_o  = '0;
    buf_wdata_o = '0;
    buf_rnw_o   = 1'b1;
    if (state == S_WRITE) begin
      buf_addr_o  = BUF_BASE;
      buf_wdata_o = {24'h0, shift};
      buf_rnw_o   = 1'b0;
    end else if (cpu_ack_o) begin
      buf_addr_o  = BUF_BASE;
    end
  end

  // Baud counter, bit index and data shift register.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      if ((state_next != state) || sample) baud_cnt <= '0;
      else if (counting)                   baud_cnt <= baud_cnt + 1'b1;
      if (state == S_START) bit_idx <= '0;
      else if ((state == S_DATA) && sample) begin
        bit_idx <= bit_idx + 1'b1;
        shift   <= {rx_s, shift[7:1]};
      end
    end
  end

  // Error/drop pulses and the saturating drop counter.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      frame_err    <= 1'b0;
      byte_dropped <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      frame_err    <= stop_bad || parity_bad;
      byte_dropped <= (state == S_WRITE) && rx_buffer_full_i;
      if ((state == S_WRITE) && rx_buffer_full_i && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign frame_err_o    = frame_err;
  assign byte_dropped_o = byte_dropped;
  assign drop_count_o   = drop_cnt;

endmodule

// File: tb/tb_uart_rx_buf_sched.sv
// Directed bench for uart_rx_buf_sched at 8 clocks per bit. Each sent frame
// schedules its expected bus write / frame error / drop pulse on an absolute
// cycle number derived from frame arithmetic (2 sync cycles + 1 detect cycle +
// half a bit + whole bits); a per-cycle compare checks every output against it.
module tb_uart_rx_buf_sched;

  localparam int          CPB  = 8;
  localparam logic [31:0] BASE = 32'h0001_0000;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS  = 10;
  localparam int WR_LAT = 87;
`else
  localparam int NBITS  = 9;
  localparam int WR_LAT = 79;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        req = 1'b0;
  logic        full = 1'b0;
  logic        empty = 1'b1;
  logic        ack;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rnw;
  logic        ferr;
  logic        dropped;
  logic [7:0]  dcnt;
  logic        busy;

  uart_rx_buf_sched #(.CLKS_PER_BIT(CPB), .BUF_BASE(BASE)) dut (
    .clk               (clk),
    .rst_n_i           (rst_n),
    .rx_i              (rx),
    .cpu_req_i         (req),
    .cpu_ack_o         (ack),
    .buf_addr_o        (addr),
    .buf_wdata_o       (wdata),
    .buf_rnw_o         (rnw),
    .rx_buffer_full_i  (full),
    .rx_buffer_empty_i (empty),
    .frame_err_o       (ferr),
    .byte_dropped_o    (dropped),
    .drop_count_o      (dcnt),
    .rx_busy_o         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  bit [7:0] exp_wr [int];
  bit       exp_fe [int];
  bit       exp_dr [int];
  int       m_cnt = 0;

  int          wr_seen = 0;
  int          fe_seen = 0;
  int          dr_seen = 0;
  int          last_wr_cyc = 0;
  logic [31:0] last_wdata = '0;
  logic        ack_in_wr = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // Per-cycle compare against the scheduled expectations.
  always @(negedge clk) begin
    logic        e_wr;
    logic        e_ack;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    if (!rst_n) m_cnt = 0;
    if (exp_dr.exists(cyc) && m_cnt != 255) m_cnt++;
    if (rnw === 1'b0) begin
      wr_seen++;
      last_wr_cyc = cyc;
      last_wdata  = wdata;
      ack_in_wr   = ack;
    end
    if (ferr === 1'b1) fe_seen++;
    if (dropped === 1'b1) dr_seen++;
    if (chk_en) begin
      e_wr    = exp_wr.exists(cyc);
      e_ack   = rst_n && req && !empty && !e_wr;
      e_addr  = (e_wr || e_ack) ? BASE : 32'h0;
      e_wdata = e_wr ? {24'h0, exp_wr[cyc]} : 32'h0;
      chk("ack",     {31'h0, ack},     {31'h0, e_ack});
      chk("addr",    addr,             e_addr);
      chk("wdata",   wdata,            e_wdata);
      chk("rnw",     {31'h0, rnw},     {31'h0, !e_wr});
      chk("ferr",    {31'h0, ferr},    {31'h0, exp_fe.exists(cyc)});
      chk("dropped", {31'h0, dropped}, {31'h0, exp_dr.exists(cyc)});
      chk("dcnt",    {24'h0, dcnt},    32'(m_cnt));
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) hold(1);
  endtask

  // Sends one frame starting now and schedules what it must produce; w is the
  // cycle on which the write (or stop-bit error) is expected.
  task automatic send(input logic [7:0] b, input bit stop_ok, input bit par_ok, output int w);
    int p;
    p = cyc;
    w = p + 3 + CPB / 2 + NBITS * CPB;
    if (!par_ok)       exp_fe[w - CPB] = 1'b1;
    else if (!stop_ok) exp_fe[w] = 1'b1;
    else begin
      exp_wr[w] = b;
      if (full) exp_dr[w + 1] = 1'b1;
    end
    rx = 1'b0;
    hold(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      hold(CPB);
    end
`ifdef UART_RX_PARITY_EN
    rx = par_ok ? ^b : ~^b;
    hold(CPB);
`endif
    rx = stop_ok;
    hold(CPB);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int p0;
    int wr0;
    int fe0;
    hold(5);
    // Reset state
    chk("rst_busy",  {31'h0, busy},    32'h0);
    chk("rst_rnw",   {31'h0, rnw},     32'h1);
    chk("rst_addr",  addr,             32'h0);
    chk("rst_wdata", wdata,            32'h0);
    chk("rst_ferr",  {31'h0, ferr},    32'h0);
    chk("rst_drop",  {31'h0, dropped}, 32'h0);
    chk("rst_dcnt",  {24'h0, dcnt},    32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    hold(3);

    // 0x55 clean frame
    p0 = cyc;
    send(8'h55, 1'b1, 1'b1, w);
    hold(2);
    chk("w55_data", last_wdata, 32'h0000_0055);
    chk("w55_lat",  32'(last_wr_cyc - p0), 32'(WR_LAT));
    chk("w55_idle", {31'h0, busy}, 32'h0);

    // 3-cycle glitch with a CPU request against an empty buffer
    wr0 = wr_seen; fe0 = fe_seen;
    req = 1'b1; empty = 1'b1;
    rx = 1'b0; hold(3);
    rx = 1'b1; hold(20);
    chk("glitch_idle", {31'h0, busy}, 32'h0);
    chk("glitch_nowr", 32'(wr_seen), 32'(wr0));
    chk("glitch_nofe", 32'(fe_seen), 32'(fe0));
    req = 1'b0;

    // 0xA3 with stop bit low, line held low afterwards
    send(8'hA3, 1'b0, 1'b1, w);
    hold(20);
    chk("a3_fe_once", 32'(fe_seen), 32'(fe0 + 1));
    chk("a3_waithi",  {31'h0, busy}, 32'h1);
    rx = 1'b1;
    hold(5);
    chk("a3_idle",    {31'h0, busy}, 32'h0);
    chk("a3_fe_once2", 32'(fe_seen), 32'(fe0 + 1));
    chk("a3_nowr",    32'(wr_seen), 32'(wr0));

    // CPU request held across a write, buffer non-empty
    empty = 1'b0; req = 1'b1;
    send(8'h3C, 1'b1, 1'b1, w);
    wait_cyc(w + 1);
    chk("cpu_ack_wr",   {31'h0, ack_in_wr}, 32'h0);
    chk("cpu_ack_next", {31'h0, ack}, 32'h1);
    chk("cpu_rnw_next", {31'h0, rnw}, 32'h1);
    chk("cpu_wdata",    last_wdata, 32'h0000_003C);
    req = 1'b0; empty = 1'b1;
    hold(3);

    // Reset in the middle of a frame
    wr0 = wr_seen;
    rx = 1'b0;
    hold(40);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", {31'h0, busy}, 32'h0);
    chk("mrst_rnw",  {31'h0, rnw},  32'h1);
    chk("mrst_addr", addr,          32'h0);
    rx = 1'b1;
    hold(3);
    rst_n = 1'b1;
    hold(100);
    chk("mrst_nowr", 32'(wr_seen), 32'(wr0));

    // Buffer full: drops and saturation
    full = 1'b1;
    send(8'h10, 1'b1, 1'b1, w);
    wait_cyc(w + 2);
    chk("drop_one",   32'(dr_seen), 32'h1);
    chk("drop_cnt1",  {24'h0, dcnt}, 32'h1);
    chk("drop_wdata", last_wdata, 32'h0000_0010);
    for (int i = 1; i < 300; i++) begin
      send(8'(i), 1'b1, 1'b1, w);
      hold(2);
    end
    wait_cyc(w + 2);
    chk("drop_300",  32'(dr_seen), 32'd300);
    chk("drop_sat",  {24'h0, dcnt}, 32'h0000_00FF);
    full = 1'b0;
    hold(3);

`ifdef UART_RX_PARITY_EN
    wr0 = wr_seen; fe0 = fe_seen;
    send(8'h07, 1'b1, 1'b0, w);
    hold(5);
    chk("par_bad_fe",  32'(fe_seen), 32'(fe0 + 1));
    chk("par_bad_nowr", 32'(wr_seen), 32'(wr0));
    send(8'h07, 1'b1, 1'b1, w);
    hold(5);
    chk("par_ok_wr",   32'(wr_seen), 32'(wr0 + 1));
    chk("par_ok_data", last_wdata, 32'h0000_0007);
`endif

    hold(10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
